vec_fetch: RTL and testbench
============================

# vec_fetch

Read-side sequencer for the tensor core's byte-wide `sram`. It takes a fetch command (base address and vector count) and drives the SRAM read port. It packs LANES consecutive bytes into one vector word and streams the vectors to the downstream compute stage over a valid/ready handshake. The block is the only master of the SRAM port while busy.

## Interface
- DATA_WIDTH, 8, SRAM word width in bits
- ADDR_WIDTH, 4, SRAM address width in bits
- LANES, 4, bytes packed per output vector (≥1)
- CNT_WIDTH, 8, width of the vector-count field

- clk  in  1  single clock; all logic rises on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe, sampled only in IDLE
- base_addr  in  ADDR_WIDTH  address of lane 0 of the first vector
- vec_count  in  CNT_WIDTH  number of vectors to fetch
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse when the command completes
- sram_cs  out  1  SRAM chip select
- sram_we  out  1  tied 0 (read only)
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_dout  in  DATA_WIDTH  SRAM read data; valid the cycle after cs=1, we=0 is sampled
- vec_valid  out  1  output vector valid
- vec_ready  in  1  downstream accept
- vec_data  out  LANES*DATA_WIDTH  packed vector; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH] = byte from the k-th address
- vec_last  out  1  qualifies the final vector of the command

## Operation
- States: IDLE, READ, DRAIN, OUT.
- IDLE → READ on start with vec_count≠0. Latch base_addr into addr_q and vec_count into remaining.
  - start with vec_count=0: stay in IDLE and pulse done the next cycle.
- READ: sram_cs=1, sram_addr=addr_q, and addr_q increments each cycle. Exactly LANES cycles, then go to DRAIN.
- Capture: a registered rd_pend (cs of the previous cycle) writes sram_dout into lane index rd_lane, which then increments. Capture happens in READ (after its first cycle) and in DRAIN.
- DRAIN: one cycle, sram_cs=0, captures the last lane, then go to OUT.
- OUT: vec_valid=1, and vec_data/vec_last stay stable until vec_valid & vec_ready.
  - On handshake, decrement remaining.
  - If the decremented remaining ≠ 0, go to READ. Addresses continue from addr_q.
  - If it is 0, go to IDLE and pulse done the cycle after.
- Address arithmetic is modulo 2^ADDR_WIDTH: the address after 2^ADDR_WIDTH−1 is 0, with no error.
- vec_last = (remaining==1) in OUT.
- start while busy is ignored. No queueing.
- While OUT is stalled, sram_cs=0, so no read is issued that could be lost.

## Timing
- Reset values: busy=0, done=0, sram_cs=0, sram_we=0, sram_addr=0, vec_valid=0, vec_data=0, vec_last=0. State returns to IDLE and all counters clear.
- Reset takes effect immediately, including mid-READ or mid-OUT. The in-flight command is discarded.
- Start sampled at edge E0:
  - sram_cs is high from after E0 through E_LANES, on addresses base … base+LANES−1.
  - vec_valid rises after edge E_{LANES+1}, a latency of LANES+1 cycles (5 for LANES=4).
- Throughput with vec_ready held at 1: one vector per LANES+2 cycles (READ ×LANES, DRAIN, OUT).
- done rises in the cycle after the final handshake edge. In that same cycle busy=0.

## Structure
- Shared package `tensor_core_pkg`:
  - the fetch-state enum (IDLE/READ/DRAIN/OUT);
  - the default DATA_WIDTH/ADDR_WIDTH constants shared with `sram`.
- Sub-module `vec_pack_reg`:
  - a LANES-wide byte shift/index register with write-enable, lane index and clear;
  - holds vec_data.
- The FSM, counters and address generation stay in `vec_fetch`.

## Test plan
All scenarios use an `sram` instance with the same parameters, preloaded by the bench with mem[i]=8'h10+i, and LANES=4.

- base=0, count=1, vec_ready=1:
  - sram_cs is high for exactly 4 cycles on addresses 0–3;
  - vec_valid is high 5 cycles after the start edge with vec_data=32'h13121110 and vec_last=1;
  - done pulses one cycle after the handshake.
- base=14, count=1: wrap-around gives addresses 14,15,0,1 and vec_data=32'h11101F1E.
- base=2, count=3, vec_ready low for 3 cycles on the first vector:
  - vec_data holds 32'h15141312 stable and sram_cs stays 0 during the stall;
  - the next vectors are 32'h19181716 and 32'h1D1C1B1A;
  - vec_last is high only on the third vector;
  - done fires exactly once.
- count=0: busy stays 0, done pulses one cycle after start, and vec_valid never asserts.
- start pulsed again mid-READ: it is ignored, and the addresses and data match the first command.
- rst_n dropped during READ:
  - all outputs are at their reset values while rst_n is low;
  - after release, a new base=4, count=1 command yields 32'h17161514.

Source files
------------

// File: rtl/tensor_core_pkg.sv
// Shared tensor-core definitions: fetch FSM states and SRAM geometry defaults.
package tensor_core_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        OUT
    } fetch_state_t;

    // Width of an index that counts 0..n-1 (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vec_fetch_if.sv
// Bus bundle of vec_fetch: command, SRAM read port and vector stream.
interface vec_fetch_if
    import tensor_core_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LANES      = 4,
    parameter int CNT_WIDTH  = 8
);
    logic                        start;
    logic [ADDR_WIDTH-1:0]       base_addr;
    logic [CNT_WIDTH-1:0]        vec_count;
    logic                        busy;
    logic                        done;
    logic                        sram_cs;
    logic                        sram_we;
    logic [ADDR_WIDTH-1:0]       sram_addr;
    logic [DATA_WIDTH-1:0]       sram_dout;
    logic                        vec_valid;
    logic                        vec_ready;
    logic [LANES*DATA_WIDTH-1:0] vec_data;
    logic                        vec_last;

    modport master (
        input  start, base_addr, vec_count, sram_dout, vec_ready,
        output busy, done, sram_cs, sram_we, sram_addr, vec_valid, vec_data, vec_last
    );

    modport slave (
        output start, base_addr, vec_count, sram_dout, vec_ready,
        input  busy, done, sram_cs, sram_we, sram_addr, vec_valid, vec_data, vec_last
    );

endinterface

// File: rtl/vec_pack_reg.sv
// Lane-indexed byte packer: each write fills the next lane of the vector word.
module vec_pack_reg
    import tensor_core_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        we,
    input  logic [DATA_WIDTH-1:0]       din,
    output logic [LANES*DATA_WIDTH-1:0] data
);
    localparam int IW = idx_width(LANES);

    logic [IW-1:0] rd_lane;

    // clr only rewinds the lane index; held data stays visible until overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data    <= '0;
            rd_lane <= '0;
        end else if (clr) begin
            rd_lane <= '0;
        end else if (we) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (rd_lane == IW'(k))
                    data[k*DATA_WIDTH +: DATA_WIDTH] <= din;
            end
            rd_lane <= (rd_lane == IW'(LANES - 1)) ? '0 : rd_lane + 1'b1;
        end
    end

endmodule

// File: rtl/vec_fetch.sv
// SRAM read sequencer: fetches LANES bytes per vector and streams packed vectors.
module vec_fetch
    import tensor_core_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LANES      = 4,
    parameter int CNT_WIDTH  = 8
) (
    input logic        clk,
    input logic        rst_n,
    vec_fetch_if.master bus
);
    localparam int RW = idx_width(LANES);

    fetch_state_t                state;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [CNT_WIDTH-1:0]        remaining;
    logic [RW-1:0]               rd_cnt;
    logic                        rd_pend;
    logic                        pack_clr;
    logic                        busy_q;
    logic                        done_q;
    logic                        cs_q;
    logic                        valid_q;
    logic                        last_q;
    logic [LANES*DATA_WIDTH-1:0] pack_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            remaining <= '0;
            rd_cnt    <= '0;
            rd_pend   <= 1'b0;
            pack_clr  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_q      <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            pack_clr <= 1'b0;
            rd_pend  <= cs_q;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.vec_count != '0) begin
                            state     <= READ;
                            busy_q    <= 1'b1;
                            cs_q      <= 1'b1;
                            addr_q    <= bus.base_addr;
                            remaining <= bus.vec_count;
                            rd_cnt    <= '0;
                            pack_clr  <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    // addr_q also advances on the last read so the next vector resumes there
                    addr_q <= addr_q + 1'b1;
                    if (rd_cnt == RW'(LANES - 1)) begin
                        cs_q  <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    state   <= OUT;
                    valid_q <= 1'b1;
                    last_q  <= (remaining == CNT_WIDTH'(1));
                end
                OUT: begin
                    if (bus.vec_ready) begin
                        valid_q   <= 1'b0;
                        last_q    <= 1'b0;
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_WIDTH'(1)) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state    <= READ;
                            cs_q     <= 1'b1;
                            rd_cnt   <= '0;
                            pack_clr <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    vec_pack_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES)
    ) u_pack (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pack_clr),
        .we    (rd_pend),
        .din   (bus.sram_dout),
        .data  (pack_data)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sram_cs   = cs_q;
    assign bus.sram_we   = 1'b0;
    assign bus.sram_addr = addr_q;
    assign bus.vec_valid = valid_q;
    assign bus.vec_data  = pack_data;
    assign bus.vec_last  = last_q;

endmodule

// File: tb/tb_vec_fetch.sv
// Bench for vec_fetch: table vectors, corner sequences and random commands vs. a reference model.
module tb_vec_fetch;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int LN = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [DW-1:0] mem [1<<AW];

    vec_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANES(LN), .CNT_WIDTH(CW)) bus ();

    vec_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANES(LN), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: registered read, data valid the cycle after cs.
    always @(posedge clk) begin
        if (bus.sram_cs && !bus.sram_we)
            bus.sram_dout <= mem[bus.sram_addr];
    end

    typedef struct {
        logic [AW-1:0]    base;
        logic [CW-1:0]    count;
        int               stall;
        logic [LN*DW-1:0] exp_first;
        logic [LN*DW-1:0] exp_last;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic logic [LN*DW-1:0] model_vec(input int base, input int v);
        logic [LN*DW-1:0] w;
        w = '0;
        for (int k = 0; k < LN; k++)
            w[k*DW +: DW] = 8'(8'h10 + ((base + v*LN + k) % (1 << AW)));
        return w;
    endfunction

    function automatic logic [63:0] out_snapshot();
        return {28'd0, bus.busy, bus.done, bus.sram_cs, bus.sram_we, bus.sram_addr,
                bus.vec_valid, bus.vec_last, bus.vec_data};
    endfunction

    // Issue one command and follow it to completion; restart_cyc>=0 injects a spurious start.
    task automatic run_cmd(input logic [AW-1:0] base, input logic [CW-1:0] count,
                           input int stall, input bit rnd, input int restart_cyc,
                           output logic [LN*DW-1:0] first_d, output logic [LN*DW-1:0] last_d);
        logic [AW-1:0]      addrs [$];
        logic [LN*DW-1:0]   vecs  [$];
        bit                 lasts [$];
        logic [LN*DW:0]     held;
        bit                 held_v = 0;
        bit                 stall_ok = 1;
        bit                 busy_ok = 1;
        bit                 rdy;
        int                 cyc = 0;
        int                 first_valid = -1;
        int                 hs_cyc = -1;
        int                 done_cnt = 0;
        int                 done_cyc = -1;
        bit                 done_busy = 0;
        int                 stall_left = stall;

        @(negedge clk);
        bus.start = 1'b1;
        bus.base_addr = base;
        bus.vec_count = count;
        bus.vec_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < 600) begin
            if (cyc == restart_cyc) begin
                bus.start = 1'b1;
                bus.base_addr = base + 4'd7;
                bus.vec_count = count + 8'd2;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.sram_cs) addrs.push_back(bus.sram_addr);
            if (bus.sram_cs && bus.vec_valid) stall_ok = 0;
            if ((hs_cyc < 0 || cyc <= hs_cyc) && !bus.busy) busy_ok = 0;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    done_busy = bus.busy;
                end
            end
            if (bus.vec_valid && hs_cyc < 0) begin
                if (first_valid < 0) first_valid = cyc;
                if (held_v && {bus.vec_last, bus.vec_data} !== held) stall_ok = 0;
                if (stall_left > 0) begin
                    rdy = 0;
                    stall_left--;
                end else begin
                    rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                bus.vec_ready = rdy;
                if (rdy) begin
                    vecs.push_back(bus.vec_data);
                    lasts.push_back(bus.vec_last);
                    held_v = 0;
                    if (vecs.size() == int'(count)) hs_cyc = cyc;
                end else begin
                    held = {bus.vec_last, bus.vec_data};
                    held_v = 1;
                end
            end else begin
                bus.vec_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                held_v = 0;
            end
            if (hs_cyc >= 0 && cyc >= hs_cyc + 3) break;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        bus.vec_ready = 1'b0;

        check("completed", 64'(hs_cyc >= 0), 64'd1);
        check("latency", 64'(first_valid), 64'(LN + 1));
        check("busy_held", 64'(busy_ok), 64'd1);
        check("stall_hold", 64'(stall_ok), 64'd1);
        check("n_vec", 64'(vecs.size()), 64'(count));
        for (int v = 0; v < vecs.size(); v++) begin
            check("vec_data", 64'(vecs[v]), 64'(model_vec(int'(base), v)));
            check("vec_last", 64'(lasts[v]), 64'(v == int'(count) - 1));
        end
        check("n_reads", 64'(addrs.size()), 64'(int'(count) * LN));
        for (int j = 0; j < addrs.size(); j++)
            check("rd_addr", 64'(addrs[j]), 64'((int'(base) + j) % (1 << AW)));
        check("done_cnt", 64'(done_cnt), 64'd1);
        check("done_time", 64'(done_cyc), 64'(hs_cyc + 1));
        check("done_busy", 64'(done_busy), 64'd0);
        first_d = (vecs.size() > 0) ? vecs[0] : '0;
        last_d  = (vecs.size() > 0) ? vecs[vecs.size()-1] : '0;
    endtask

    initial begin
        logic [LN*DW-1:0] f, l;
        bit seen_valid, seen_busy;

        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(8'h10 + i);
        tbl[0] = '{base: 4'd0,  count: 8'd1, stall: 0, exp_first: 32'h13121110, exp_last: 32'h13121110};
        tbl[1] = '{base: 4'd14, count: 8'd1, stall: 0, exp_first: 32'h11101F1E, exp_last: 32'h11101F1E};
        tbl[2] = '{base: 4'd2,  count: 8'd3, stall: 3, exp_first: 32'h15141312, exp_last: 32'h1D1C1B1A};
        tbl[3] = '{base: 4'd4,  count: 8'd1, stall: 0, exp_first: 32'h17161514, exp_last: 32'h17161514};
        tbl[4] = '{base: 4'd13, count: 8'd2, stall: 1, exp_first: 32'h101F1E1D, exp_last: 32'h14131211};

        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.vec_count = '0;
        bus.vec_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_snapshot(), 64'd0);
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            run_cmd(tbl[t].base, tbl[t].count, tbl[t].stall, 1'b0, -1, f, l);
            check("tbl_first", 64'(f), 64'(tbl[t].exp_first));
            check("tbl_last", 64'(l), 64'(tbl[t].exp_last));
        end

        // Zero-length command: immediate done, never busy or valid.
        @(negedge clk);
        bus.start = 1'b1;
        bus.vec_count = '0;
        bus.base_addr = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        check("zero_done", 64'(bus.done), 64'd1);
        check("zero_busy", 64'(bus.busy), 64'd0);
        seen_valid = 0;
        seen_busy = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) check("zero_done_pulse", 64'(bus.done), 64'd0);
            seen_valid |= bus.vec_valid;
            seen_busy  |= bus.busy;
        end
        check("zero_no_valid", 64'(seen_valid), 64'd0);
        check("zero_no_busy", 64'(seen_busy), 64'd0);

        // Second start mid-READ must be ignored.
        run_cmd(4'd5, 8'd1, 0, 1'b0, 1, f, l);
        check("restart_data", 64'(f), 64'h18171615);

        // Reset dropped mid-READ, then a fresh command.
        @(negedge clk);
        bus.start = 1'b1;
        bus.base_addr = 4'd3;
        bus.vec_count = 8'd2;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("pre_reset_cs", 64'(bus.sram_cs), 64'd1);
        rst_n = 1'b0;
        #1;
        check("reset_async", out_snapshot(), 64'd0);
        repeat (2) @(negedge clk);
        check("reset_hold", out_snapshot(), 64'd0);
        rst_n = 1'b1;
        run_cmd(4'd4, 8'd1, 0, 1'b0, -1, f, l);
        check("post_reset_data", 64'(f), 64'h17161514);

        for (int r = 0; r < 20; r++)
            run_cmd(AW'($urandom_range(0, 15)), CW'($urandom_range(1, 4)),
                    int'($urandom_range(0, 3)), 1'b1, -1, f, l);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
